// File: rtl/ifetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch_pkg : shared types and constants for the fetch stage       |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
package ifetch_pkg;

  localparam logic [31:0] IFETCH_NOP = 32'hE1A0_0000;  // MOV r0, r0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch_if : instruction-memory request/response channel           |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
interface ifetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch_buf : synchronous FIFO of fetched {pc, instr} entries      |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   head,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_entry_t    mem [BUF_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_pop;

  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // The issue rule reserves a slot for every request; a push into a full buffer is a bug upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !do_pop && !clear && count == CW'(BUF_DEPTH)));

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch : instruction-fetch stage with buffered, flushable fetch   |
// | Optional macro IFETCH_PERF_EN adds fetch/flush event counters.    |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  ifetch_if.master    imem,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [31:0] PCPlus8
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(2 * BUF_DEPTH + 1);
  localparam int RW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [BW-1:0] buf_count;
  logic [RW-1:0] reserve;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          buf_empty;
  logic          pop;
  logic          accept;
  logic          keep;

  assign buf_empty   = (buf_count == '0);
  assign InstrValidF = ~buf_empty;
  assign pop         = InstrValidF & ~stall & ~BranchTakenE;

  // Slots already promised: buffered words not leaving plus live (non-stale) requests.
  assign reserve = RW'(buf_count) - RW'(pop) + RW'(inflight) - RW'(discard);

  assign imem.req_valid = ~reset & ~BranchTakenE
                        & (reserve < RW'(BUF_DEPTH))
                        & (inflight < CW'(2 * BUF_DEPTH));
  assign imem.addr      = fetch_pc;
  assign accept         = imem.req_valid & imem.req_ready;
  assign keep           = imem.rsp_valid & (discard == '0) & ~BranchTakenE;
  assign push_entry     = '{pc: rsp_pc, instr: imem.rsp_data};

  assign InstrF  = buf_empty ? IFETCH_NOP : head.instr;
  assign PCPlus8 = (buf_empty ? rsp_pc : head.pc) + 32'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(imem.rsp_valid);
      if (BranchTakenE) begin
        fetch_pc <= BranchTargetE;
        rsp_pc   <= BranchTargetE;
        discard  <= inflight + CW'(accept) - CW'(imem.rsp_valid);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (keep) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (imem.rsp_valid && discard != '0) begin
          discard <= discard - 1'b1;
        end
      end
    end
  end

  ifetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (BranchTakenE),
    .push  (keep),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (buf_count)
  );

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_flush_cnt <= perf_flush_cnt + 32'(BranchTakenE);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ifetch : directed self-checking bench for the fetch stage      |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] target = 32'h0;
  logic        mem_ready = 1'b1;
  int          lat = 1;
  int          checks = 0;
  int          fails = 0;

  logic [31:0] InstrF, PCPlus8;
  logic        InstrValidF;
  logic [31:0] w_instr, w_pc8;
  logic        w_valid;
  logic        w_br = 1'b0;
  logic        w_stall = 1'b0;
  logic [31:0] w_target = 32'h0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_perf_fetch, w_perf_flush;
`endif

  ifetch_if mif ();
  ifetch_if wif ();

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .BranchTakenE  (br),
    .BranchTargetE (target),
    .imem          (mif),
    .InstrF        (InstrF),
    .InstrValidF   (InstrValidF),
    .PCPlus8       (PCPlus8)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_w (
    .clk           (clk),
    .reset         (reset),
    .stall         (w_stall),
    .BranchTakenE  (w_br),
    .BranchTargetE (w_target),
    .imem          (wif),
    .InstrF        (w_instr),
    .InstrValidF   (w_valid),
    .PCPlus8       (w_pc8)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (w_perf_fetch),
    .perf_flush_cnt (w_perf_flush)
`endif
  );

  // Memory for the main DUT: returns the address as data after `lat` cycles, in order.
  logic [3:0]  pv;
  logic [31:0] pa [0:3];
  always @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv <= {pv[2:0], mif.req_valid & mif.req_ready};
    end
    pa[0] <= mif.addr;
    for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
  end
  assign mif.req_ready = mem_ready;
  assign mif.rsp_valid = pv[lat-1];
  assign mif.rsp_data  = pa[lat-1];

  // Zero-wait memory for the wrap-around instance.
  logic        wv;
  logic [31:0] wd;
  always @(posedge clk) begin
    if (reset) wv <= 1'b0;
    else       wv <= wif.req_valid & wif.req_ready;
    wd <= wif.addr;
  end
  assign wif.req_ready = 1'b1;
  assign wif.rsp_valid = wv;
  assign wif.rsp_data  = wd;

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < lat; i++) n += int'(pv[i]);
    return n;
  endfunction

  task automatic do_reset(input int latency);
    reset = 1'b1;
    stall = 1'b0;
    br    = 1'b0;
    lat   = latency;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lat   = 1;
    repeat (3) @(negedge clk);
    checks++; if (mif.req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b want 0", mif.req_valid); end
    checks++; if (InstrValidF !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", InstrValidF); end
    checks++; if (InstrF !== IFETCH_NOP) begin fails++; $display("FAIL reset_instr got %h want %h", InstrF, IFETCH_NOP); end
    checks++; if (PCPlus8 !== 32'h8) begin fails++; $display("FAIL reset_pcplus8 got %h want 00000008", PCPlus8); end
    checks++; if (w_pc8 !== 32'h0) begin fails++; $display("FAIL reset_wrap_pcplus8 got %h want 00000000", w_pc8); end
  endtask

  task automatic test_stream();
    do_reset(1);
    #1;
    checks++; if (mif.req_valid !== 1'b1 || mif.addr !== 32'h0) begin fails++; $display("FAIL stream_first_req got v=%b a=%h want v=1 a=0", mif.req_valid, mif.addr); end
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0) begin fails++; $display("FAIL stream_no_bypass got %b want 0", InstrValidF); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'(4*k)) begin fails++; $display("FAIL stream_instr[%0d] got v=%b %h want v=1 %h", k, InstrValidF, InstrF, 32'(4*k)); end
      checks++; if (PCPlus8 !== 32'(4*k + 8)) begin fails++; $display("FAIL stream_pcplus8[%0d] got %h want %h", k, PCPlus8, 32'(4*k + 8)); end
    end
  endtask

  // Continues from test_stream: head is 20 with 24 returning this cycle.
  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (mif.req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_blocked got %b want 0", mif.req_valid); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'd20 || PCPlus8 !== 32'd28) begin fails++; $display("FAIL stall_hold got v=%b %h pc8=%h want v=1 00000014 pc8=0000001c", InstrValidF, InstrF, PCPlus8); end
      checks++; if (mif.req_valid !== 1'b0) begin fails++; $display("FAIL stall_full_req got %b want 0", mif.req_valid); end
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'(24 + 4*k)) begin fails++; $display("FAIL stall_resume[%0d] got v=%b %h want v=1 %h", k, InstrValidF, InstrF, 32'(24 + 4*k)); end
    end
  endtask

  task automatic test_latency3();
    logic [31:0] nxt = 32'h0;
    int got = 0;
    do_reset(3);
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      checks++; if (outstanding() > 2) begin fails++; $display("FAIL lat3_outstanding got %0d want <=2", outstanding()); end
      if (InstrValidF) begin
        checks++; if (InstrF !== nxt || PCPlus8 !== nxt + 32'd8) begin fails++; $display("FAIL lat3_order got %h pc8=%h want %h pc8=%h", InstrF, PCPlus8, nxt, nxt + 32'd8); end
        nxt += 32'd4;
        got++;
      end
    end
    checks++; if (got != 8) begin fails++; $display("FAIL lat3_budget got %0d instrs want 8", got); end
  endtask

  task automatic test_redirect();
    int n;
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    checks++; if (outstanding() != 2 || InstrValidF !== 1'b0) begin fails++; $display("FAIL redir_setup got out=%0d v=%b want out=2 v=0", outstanding(), InstrValidF); end
    br = 1'b1;
    target = 32'h100;
    #1;
    checks++; if (mif.req_valid !== 1'b0) begin fails++; $display("FAIL redir_no_issue got %b want 0", mif.req_valid); end
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (mif.req_valid !== 1'b1 || mif.addr !== 32'h100) begin fails++; $display("FAIL redir_target_req got v=%b a=%h want v=1 a=00000100", mif.req_valid, mif.addr); end
    checks++; if (InstrValidF !== 1'b0 || PCPlus8 !== 32'h108) begin fails++; $display("FAIL redir_empty got v=%b pc8=%h want v=0 pc8=00000108", InstrValidF, PCPlus8); end
    n = 0;
    while (!InstrValidF && n < 12) begin @(negedge clk); n++; end
    checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h100 || PCPlus8 !== 32'h108) begin fails++; $display("FAIL redir_first got v=%b %h pc8=%h want v=1 00000100 pc8=00000108", InstrValidF, InstrF, PCPlus8); end
    @(negedge clk);
    n = 0;
    while (!InstrValidF && n < 12) begin @(negedge clk); n++; end
    checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h104) begin fails++; $display("FAIL redir_second got v=%b %h want v=1 00000104", InstrValidF, InstrF); end
  endtask

  task automatic test_redirect_collide();
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch0, flush0;
`endif
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h4 || mif.rsp_valid !== 1'b1) begin fails++; $display("FAIL coll_setup got v=%b %h rsp=%b want v=1 00000004 rsp=1", InstrValidF, InstrF, mif.rsp_valid); end
`ifdef IFETCH_PERF_EN
    fetch0 = perf_fetch_cnt;
    flush0 = perf_flush_cnt;
`endif
    br = 1'b1;
    target = 32'h200;
    @(negedge clk);
    br = 1'b0;
    #1;
    checks++; if (InstrValidF !== 1'b0 || PCPlus8 !== 32'h208) begin fails++; $display("FAIL coll_empty got v=%b pc8=%h want v=0 pc8=00000208", InstrValidF, PCPlus8); end
    checks++; if (mif.req_valid !== 1'b1 || mif.addr !== 32'h200) begin fails++; $display("FAIL coll_req got v=%b a=%h want v=1 a=00000200", mif.req_valid, mif.addr); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== fetch0) begin fails++; $display("FAIL coll_perf_fetch got %0d want %0d", perf_fetch_cnt, fetch0); end
    checks++; if (perf_flush_cnt !== flush0 + 32'd1) begin fails++; $display("FAIL coll_perf_flush got %0d want %0d", perf_flush_cnt, flush0 + 32'd1); end
`endif
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0) begin fails++; $display("FAIL coll_stale_dropped got %b want 0", InstrValidF); end
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h200 || PCPlus8 !== 32'h208) begin fails++; $display("FAIL coll_target got v=%b %h pc8=%h want v=1 00000200 pc8=00000208", InstrValidF, InstrF, PCPlus8); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset(1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = 32'hFFFF_FFF8 + 32'(4*k);
      checks++; if (w_valid !== 1'b1 || w_instr !== e) begin fails++; $display("FAIL wrap_instr[%0d] got v=%b %h want v=1 %h", k, w_valid, w_instr, e); end
      checks++; if (w_pc8 !== e + 32'd8) begin fails++; $display("FAIL wrap_pcplus8[%0d] got %h want %h", k, w_pc8, e + 32'd8); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency3();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
